// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates two byte-wide requesters onto a single-port-style RAM that has
//   separate read and write address buses and a one-cycle registered read.
//   Grants are combinational; the access is accepted in the cycle the grant
//   is high. Read data, read strobes and out-of-range flags return one cycle
//   later. Tie-breaking is round-robin. A requester may optionally lock the
//   arbiter for up to LOCK_MAX consecutive cycles.
//
// Optional feature macro: MEM_ARBITER_LOCK_EN
//   defined   -> lock0/lock1 move the arbiter into an ownership state
//   undefined -> lock inputs have no effect, pure round-robin
//
// Parameters
//   MEM_LENGTH : number of valid RAM bytes; addresses >= MEM_LENGTH are errors
//   LOCK_MAX   : longest ownership run, in cycles spent in the owned state
//
// Ports
//   clk, rst_n                 : clock, synchronous active-low reset
//   reqN, weN, addrN, wdataN   : requester N access (we=1 write, 0 read)
//   lockN                      : keep ownership after the current grant
//   gntN                       : combinational grant
//   rvalidN, rdataN            : read return, one cycle after the grant
//   errN                       : out-of-range flag, one cycle after the grant
//   ram_read_address           : RAM read address (holds when no read)
//   ram_write_address          : RAM write address
//   ram_data_in                : RAM write data
//   ram_write_enable           : RAM write strobe
//   ram_data_out               : RAM read data, valid the cycle after address
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_LENGTH = 255,
  parameter int LOCK_MAX   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic        lock0,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  output logic        err0,
  output logic        err1,
  output logic [15:0] ram_read_address,
  output logic [15:0] ram_write_address,
  output logic [7:0]  ram_data_in,
  output logic        ram_write_enable,
  input  logic [7:0]  ram_data_out
);

`ifdef MEM_ARBITER_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_MAX - 1);
  localparam logic [16:0]       MEM_LEN_W = 17'(MEM_LENGTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Requester that wins when both ask in IDLE.
  logic               rr_q, rr_d;
  logic [1:0]         rvalid_q, rvalid_d;
  logic [1:0]         err_q, err_d;
  logic [15:0]        raddr_q, raddr_d;

  logic [1:0]         gnt;
  logic               any_gnt;
  logic               sel;
  logic               sel_we;
  logic [15:0]        sel_addr;
  logic [7:0]         sel_wdata;
  logic               sel_oor;
  logic               rd_hit;

  // Arbitration and ownership FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt     = 2'b00;

    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          gnt = rr_q ? 2'b10 : 2'b01;
        end else begin
          gnt = {req1, req0};
        end
      end
      OWN0: begin
        gnt   = {1'b0, req0};
        cnt_d = cnt_q + CNT_W'(1);
        // Leave after this cycle if the owner lets go or its run is used up.
        if (!req0 || !lock0 || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end
      end
      OWN1: begin
        gnt   = {req1, 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (!req1 || !lock1 || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // No grant may escape while reset is held.
    gnt = gnt & {2{rst_n}};

    // The requester just served loses the next tie; this also hands the
    // arbiter to the other side when an ownership run expires.
    if (gnt[0]) begin
      rr_d = 1'b1;
    end else if (gnt[1]) begin
      rr_d = 1'b0;
    end

    if (LOCK_EN && (state_q == IDLE)) begin
      if (gnt[0] && lock0) begin
        state_d = OWN0;
        cnt_d   = '0;
      end else if (gnt[1] && lock1) begin
        state_d = OWN1;
        cnt_d   = '0;
      end
    end
  end

  // Granted access steering and RAM-side controls.
  always_comb begin
    any_gnt   = |gnt;
    sel       = gnt[1];
    sel_we    = sel ? we1    : we0;
    sel_addr  = sel ? addr1  : addr0;
    sel_wdata = sel ? wdata1 : wdata0;
    sel_oor   = ({1'b0, sel_addr} >= MEM_LEN_W);
    rd_hit    = any_gnt && !sel_we && !sel_oor;

    // The read address register only moves on an accepted in-range read.
    raddr_d   = rd_hit ? sel_addr : raddr_q;
    rvalid_d  = (any_gnt && !sel_we) ? gnt : 2'b00;
    err_d     = (any_gnt && sel_oor) ? gnt : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_q     <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      raddr_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      raddr_q  <= raddr_d;
    end
  end

  assign gnt0              = gnt[0];
  assign gnt1              = gnt[1];
  assign ram_write_enable  = any_gnt && sel_we && !sel_oor;
  assign ram_write_address = sel_addr;
  assign ram_data_in       = sel_wdata;
  assign ram_read_address  = raddr_d;

  // Returns are masked by rst_n so a read accepted just before reset is
  // dropped even though its strobe was already registered.
  assign rvalid0 = rvalid_q[0] && rst_n;
  assign rvalid1 = rvalid_q[1] && rst_n;
  assign err0    = err_q[0] && rst_n;
  assign err1    = err_q[1] && rst_n;
  // Out-of-range reads return zero rather than whatever the RAM presents.
  assign rdata0  = (rvalid0 && !err_q[0]) ? ram_data_out : 8'h00;
  assign rdata1  = (rvalid1 && !err_q[1]) ? ram_data_out : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int MEML = 255;
  localparam int LM   = 4;

`ifdef MEM_ARBITER_LOCK_EN
  localparam bit TB_LOCK = 1'b1;
`else
  localparam bit TB_LOCK = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] ram_read_address, ram_write_address;
  logic [7:0]  ram_data_in, ram_data_out;
  logic        ram_write_enable;

  mem_arbiter #(.MEM_LENGTH(MEML), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .err0(err0), .err1(err1),
    .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
    .ram_data_in(ram_data_in), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle registered read (read-before-write on a collision).
  logic [7:0] ram [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_write_enable) ram[ram_write_address[7:0]] <= ram_data_in;
    ram_data_out <= ram[ram_read_address[7:0]];
  end

  int pass_cnt;
  int total_cnt;

  task automatic chk_b(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  int          m_owner;     // -1: nobody holds a lock, else owning requester
  int          m_held;      // cycles already spent owned
  int          m_next;      // winner of the next tie
  logic        m_pv [2];
  logic        m_pe [2];
  logic [7:0]  m_pd [2];
  logic [15:0] m_raddr;
  bit          m_known;
  logic [7:0]  shadow [256];

  task automatic model_cycle();
    logic rq [2];
    logic wq [2];
    logic lk [2];
    logic [15:0] aq [2];
    logic [7:0]  dq [2];
    logic npv [2];
    logic npe [2];
    logic [7:0] npd [2];
    int w;
    logic exp_we;
    logic oor;
    rq[0] = req0;   rq[1] = req1;
    wq[0] = we0;    wq[1] = we1;
    lk[0] = lock0;  lk[1] = lock1;
    aq[0] = addr0;  aq[1] = addr1;
    dq[0] = wdata0; dq[1] = wdata1;
    if (!rst_n) begin
      chk_b("rst_gnt0", gnt0, 1'b0);
      chk_b("rst_gnt1", gnt1, 1'b0);
      chk_b("rst_we", ram_write_enable, 1'b0);
      chk_b("rst_rvalid0", rvalid0, 1'b0);
      chk_b("rst_rvalid1", rvalid1, 1'b0);
      chk_b("rst_err0", err0, 1'b0);
      chk_b("rst_err1", err1, 1'b0);
      if (m_known) chk_w("rst_raddr", ram_read_address, m_raddr);
      m_owner = -1; m_held = 0; m_next = 0;
      for (int i = 0; i < 2; i++) begin m_pv[i] = 1'b0; m_pe[i] = 1'b0; m_pd[i] = 8'h00; end
      m_raddr = 16'h0000; m_known = 1'b1;
      return;
    end
    w = -1;
    if (m_owner >= 0) begin
      if (rq[m_owner]) w = m_owner;
    end else if (rq[0] && rq[1]) w = m_next;
    else if (rq[0]) w = 0;
    else if (rq[1]) w = 1;

    chk_b("gnt0", gnt0, w == 0);
    chk_b("gnt1", gnt1, w == 1);
    chk_b("rvalid0", rvalid0, m_pv[0]);
    chk_b("rvalid1", rvalid1, m_pv[1]);
    chk_b("err0", err0, m_pe[0]);
    chk_b("err1", err1, m_pe[1]);
    if (m_pv[0]) chk_w("rdata0", {8'h00, rdata0}, {8'h00, m_pe[0] ? 8'h00 : m_pd[0]});
    if (m_pv[1]) chk_w("rdata1", {8'h00, rdata1}, {8'h00, m_pe[1] ? 8'h00 : m_pd[1]});

    for (int i = 0; i < 2; i++) begin npv[i] = 1'b0; npe[i] = 1'b0; npd[i] = 8'h00; end
    exp_we = 1'b0;
    if (w >= 0) begin
      oor = (int'(aq[w]) >= MEML);
      if (oor) npe[w] = 1'b1;
      if (!wq[w]) begin
        npv[w] = 1'b1;
        if (!oor) begin
          npd[w]  = shadow[aq[w][7:0]];
          m_raddr = aq[w];
        end
      end else if (!oor) begin
        exp_we = 1'b1;
        chk_w("waddr", ram_write_address, aq[w]);
        chk_w("wdata", {8'h00, ram_data_in}, {8'h00, dq[w]});
      end
    end
    chk_b("ram_we", ram_write_enable, exp_we);
    if (m_known) chk_w("raddr", ram_read_address, m_raddr);
    if (exp_we) shadow[aq[w][7:0]] = dq[w];

    if (m_owner >= 0) begin
      m_held++;
      if (m_held == LM || !lk[m_owner] || !rq[m_owner]) m_owner = -1;
    end else if (TB_LOCK && w >= 0 && lk[w]) begin
      m_owner = w;
      m_held  = 0;
    end
    if (w >= 0) m_next = 1 - w;
    for (int i = 0; i < 2; i++) begin m_pv[i] = npv[i]; m_pe[i] = npe[i]; m_pd[i] = npd[i]; end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        rs, r0, r1, w0, w1;
    logic [15:0] a0, a1;
    logic [7:0]  d0, d1;
    logic        g0, g1, we, rv0, rv1, e0, e1;
    logic [7:0]  rd0, rd1;
  } vec_t;

  function automatic vec_t v(input logic rs, r0, r1, w0, w1, input logic [15:0] a0, a1,
                             input logic [7:0] d0, d1, input logic g0, g1, we, rv0, rv1, e0, e1,
                             input logic [7:0] rd0, rd1);
    vec_t t;
    t.rs = rs; t.r0 = r0; t.r1 = r1; t.w0 = w0; t.w1 = w1;
    t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
    t.g0 = g0; t.g1 = g1; t.we = we; t.rv0 = rv0; t.rv1 = rv1; t.e0 = e0; t.e1 = e1;
    t.rd0 = rd0; t.rd1 = rd1;
    return t;
  endfunction

  task automatic drive(input logic rs, r0, r1, w0, w1, l0, l1, input logic [15:0] a0, a1,
                       input logic [7:0] d0, d1);
    rst_n = rs; req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  // mode 0: model only; 1: model + full vector; 2: model + grants only
  task automatic run_cycle(input int mode, input vec_t e);
    @(negedge clk);
    model_cycle();
    if (mode == 1) begin
      chk_b("tv_gnt0", gnt0, e.g0);
      chk_b("tv_gnt1", gnt1, e.g1);
      chk_b("tv_we", ram_write_enable, e.we);
      chk_b("tv_rvalid0", rvalid0, e.rv0);
      chk_b("tv_rvalid1", rvalid1, e.rv1);
      chk_b("tv_err0", err0, e.e0);
      chk_b("tv_err1", err1, e.e1);
      if (e.rv0) chk_w("tv_rdata0", {8'h00, rdata0}, {8'h00, e.rd0});
      if (e.rv1) chk_w("tv_rdata1", {8'h00, rdata1}, {8'h00, e.rd1});
    end else if (mode == 2) begin
      chk_b("seq_gnt0", gnt0, e.g0);
      chk_b("seq_gnt1", gnt1, e.g1);
    end
    @(posedge clk);
    #1;
  endtask

  localparam int NV = 22;
  vec_t tbl [NV];
  vec_t dummy;
  logic [7:0] lock_pat;

  initial begin
    pass_cnt = 0; total_cnt = 0;
    m_owner = -1; m_held = 0; m_next = 0; m_known = 1'b0; m_raddr = 16'h0000;
    for (int i = 0; i < 2; i++) begin m_pv[i] = 1'b0; m_pe[i] = 1'b0; m_pd[i] = 8'h00; end
    for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    dummy = v(1, 0,0,0,0, 16'h0,16'h0, 8'h0,8'h0, 0,0,0,0,0,0,0, 8'h0,8'h0);
    drive(0, 0,0,0,0,0,0, 16'h0,16'h0, 8'h0,8'h0);

    //            rs r0 r1 w0 w1  a0       a1       d0     d1     g0 g1 we rv0 rv1 e0 e1 rd0    rd1
    tbl[0]  = v(0, 1, 1, 0, 0, 16'h0010,16'h0020, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[1]  = v(1, 1, 1, 1, 1, 16'h0010,16'h0020, 8'h11, 8'h22, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[2]  = v(1, 1, 1, 1, 1, 16'h0010,16'h0020, 8'h11, 8'h22, 0, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[3]  = v(0, 1, 1, 0, 0, 16'h0010,16'h0020, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[4]  = v(1, 1, 1, 0, 0, 16'h0010,16'h0020, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[5]  = v(1, 1, 1, 0, 0, 16'h0010,16'h0020, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h11, 8'h00);
    tbl[6]  = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h22);
    tbl[7]  = v(1, 1, 0, 1, 0, 16'h0005,16'h0000, 8'hA5, 8'h00, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[8]  = v(1, 1, 0, 0, 0, 16'h0005,16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[9]  = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'hA5, 8'h00);
    tbl[10] = v(1, 1, 0, 0, 0, 16'h00FF,16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[11] = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00);
    tbl[12] = v(1, 0, 1, 0, 0, 16'h0000,16'h0020, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[13] = v(1, 0, 1, 0, 1, 16'h0000,16'h0020, 8'h00, 8'h99, 0, 1, 1, 0, 1, 0, 0, 8'h00, 8'h22);
    tbl[14] = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[15] = v(1, 0, 1, 0, 1, 16'h0000,16'h0100, 8'h00, 8'h77, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[16] = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
    tbl[17] = v(1, 1, 0, 0, 0, 16'h0010,16'h0000, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[18] = v(0, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[19] = v(1, 1, 1, 0, 0, 16'h0010,16'h0020, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
    tbl[20] = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h11, 8'h00);
    tbl[21] = v(1, 0, 0, 0, 0, 16'h0000,16'h0000, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rs, tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, 1'b0, 1'b0,
            tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      run_cycle(1, tbl[i]);
    end

    // Lock0 held with both requesting: a locked run of LM+1 grants then a
    // hand-over when locking is built in, plain alternation otherwise.
`ifdef MEM_ARBITER_LOCK_EN
    lock_pat = 8'b1101_1111;
`else
    lock_pat = 8'b0101_0101;
`endif
    drive(0, 0,0,0,0,0,0, 16'h0,16'h0, 8'h0,8'h0);
    run_cycle(0, dummy);
    for (int i = 0; i < 8; i++) begin
      drive(1, 1,1,0,0,1,0, 16'h0001,16'h0002, 8'h0,8'h0);
      dummy.g0 = lock_pat[i];
      dummy.g1 = !lock_pat[i];
      run_cycle(2, dummy);
    end
    drive(1, 0,0,0,0,0,0, 16'h0,16'h0, 8'h0,8'h0);
    run_cycle(0, dummy);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra0, ra1;
      ra0 = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(250, 400)) : 16'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(250, 400)) : 16'($urandom_range(0, 31));
      drive($urandom_range(0, 59) != 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            ra0, ra1, 8'($urandom), 8'($urandom));
      run_cycle(0, dummy);
    end
    drive(1, 0,0,0,0,0,0, 16'h0,16'h0, 8'h0,8'h0);
    run_cycle(0, dummy);
    run_cycle(0, dummy);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LENGTH, default 255, the number of valid RAM bytes; addresses >= MEM_LENGTH are out of range.
REQ-002 SHALL have parameter LOCK_MAX, default 16, the maximum number of consecutive cycles one requester may hold a lock.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1, input, 1 bit each: access request.
REQ-006 SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, 16 bits each: byte address.
REQ-008 SHALL have ports wdata0/wdata1, input, 8 bits each: write data.
REQ-009 SHALL have ports lock0/lock1, input, 1 bit each: request to keep ownership after the current grant.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 bit each: combinational grant; the access is accepted in the cycle it is asserted.
REQ-011 SHALL have ports rvalid0/rvalid1, output, 1 bit each, plus rdata0/rdata1, output, 8 bits each: registered read-return strobe and data.
REQ-012 SHALL have ports err0/err1, output, 1 bit each: registered out-of-range flag.
REQ-013 SHALL have ports ram_read_address and ram_write_address, output, 16 bits each; ram_data_in, output, 8 bits; ram_write_enable, output, 1 bit; ram_data_out, input, 8 bits (RAM read data, one-cycle registered latency).

Function
REQ-014 SHALL grant at most one requester per cycle; gntN SHALL only be asserted while reqN is high.
REQ-015 SHALL keep an FSM with states IDLE, OWN0 and OWN1.
REQ-016 In IDLE, SHALL arbitrate round-robin: with both requesting, the requester not granted most recently wins; with one requesting, that requester wins.
REQ-017 A grant to N with lockN=1 SHALL move the FSM to OWNN; IDLE SHALL otherwise be kept.
REQ-018 In OWNN, SHALL grant only requester N; the other requester waits; OWNN SHALL return to IDLE when the lock counter reaches LOCK_MAX, or on a cycle where lockN=0 or reqN=0.
REQ-019 The lock counter SHALL clear on entry to OWNN and increment each cycle in OWNN; the LOCK_MAX exit SHALL update the round-robin pointer so the other requester wins next if requesting.
REQ-020 For a granted in-range write, SHALL drive ram_write_address=addrN, ram_data_in=wdataN and ram_write_enable=1 in the same cycle; ram_write_enable SHALL be 0 in every other cycle.
REQ-021 For a granted in-range read in cycle T, SHALL drive ram_read_address=addrN in T, and assert rvalidN with rdataN=ram_data_out in T+1 for exactly one cycle.
REQ-022 For a granted out-of-range access in T, SHALL suppress ram_write_enable and assert errN in T+1; for a read, SHALL also assert rvalidN with rdataN=8'h00.
REQ-023 Back-to-back grants SHALL be supported, one per cycle; a read then a write to the same address in consecutive cycles SHALL return the pre-write data.
REQ-024 When idle, ram_read_address SHALL hold its last value.

Reset
REQ-025 While rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the lock counter to 0, and the round-robin pointer so requester 0 wins first.
REQ-026 While rst_n=0 at a clock edge, rvalidN, errN and rdataN SHALL be set to 0 and ram_read_address to 0.
REQ-027 While rst_n is low, gntN and ram_write_enable SHALL be forced to 0.
REQ-028 A read granted in the cycle before reset is asserted SHALL NOT produce rvalid.

Configuration
REQ-029 With macro MEM_ARBITER_LOCK_EN defined, SHALL implement locking per REQ-017..REQ-019.
REQ-030 Without MEM_ARBITER_LOCK_EN, lock0/lock1 SHALL be ignored, the FSM SHALL remain in IDLE, and arbitration SHALL be pure round-robin.

Verification
REQ-031 Bench SHALL cover: both req, reads at 0x0010 and 0x0020 after reset -> gnt0 in cycle 1, gnt1 in cycle 2, rvalid0 in cycle 2, rvalid1 in cycle 3.
REQ-032 Bench SHALL cover: req0 write 0x0005 data 0xA5, then a read of 0x0005 -> rdata0=0xA5 with rvalid0 one cycle after the read grant.
REQ-033 Bench SHALL cover: req0 read at 0x00FF with MEM_LENGTH=255 -> ram_write_enable=0, rvalid0=1, rdata0=0x00 and err0=1 in the next cycle.
REQ-034 Bench SHALL cover (MEM_ARBITER_LOCK_EN, LOCK_MAX=4): lock0=1 with req0 and req1 held continuously -> gnt0 for 5 consecutive cycles, then gnt1.
REQ-035 Bench SHALL cover: rst_n driven low for 1 cycle during a pending read -> no rvalid, then requester 0 wins first.
REQ-036 Bench SHALL cover: no macro, lock0=1 with both requesting -> grants alternate every cycle.
